// File: rtl/data_buffer_if.sv
// rtl/data_buffer_if.sv - cache-word stream in, parallel FMA operand set out
interface data_buffer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_FMAS   = 4
);
   logic                           start_in;
   logic                           word_valid_in;
   logic [DATA_WIDTH-1:0]          word_in;
   logic                           fma_ready_in;
   logic                           busy_out;
   logic                           fma_valid_out;
   logic [NUM_FMAS*DATA_WIDTH-1:0] fma_a_out;
   logic [NUM_FMAS*DATA_WIDTH-1:0] fma_b_out;
   logic [NUM_FMAS*DATA_WIDTH-1:0] fma_c_out;
   logic                           done_out;
   logic                           overrun_out;

   modport slave (
      input  start_in, word_valid_in, word_in, fma_ready_in,
      output busy_out, fma_valid_out, fma_a_out, fma_b_out, fma_c_out,
             done_out, overrun_out
   );

   modport master (
      output start_in, word_valid_in, word_in, fma_ready_in,
      input  busy_out, fma_valid_out, fma_a_out, fma_b_out, fma_c_out,
             done_out, overrun_out
   );
endinterface

// File: rtl/data_buffer.sv
// rtl/data_buffer.sv - collects a fixed burst of cache words into per-FMA a/b/c operand registers
module data_buffer #(
   parameter int DATA_WIDTH    = 16,
   parameter int NUM_FMAS      = 4,
   parameter int WORDS_PER_FMA = 3
) (
   input  logic         clk_in,
   input  logic         rst_n_in,
   data_buffer_if.slave bus
);
   localparam int TOTAL = NUM_FMAS * WORDS_PER_FMA;
   localparam int CNT_W = $clog2(TOTAL);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

   typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      count_q;
   logic                  overrun_q;
   logic [DATA_WIDTH-1:0] op_q [NUM_FMAS][WORDS_PER_FMA];
   logic                  start_take;
   logic                  word_take;

   assign start_take = (state_q == IDLE) && bus.start_in;
   assign word_take  = (state_q == FILL) && bus.word_valid_in;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start_in) state_d = FILL;
         FILL:    if (bus.word_valid_in && count_q == LAST) state_d = PRESENT;
         PRESENT: if (bus.fma_ready_in) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Counter parks on the last index; the next start clears it.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)                         count_q <= '0;
      else if (start_take)                   count_q <= '0;
      else if (word_take && count_q != LAST) count_q <= count_q + 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NUM_FMAS; i++)
            for (int j = 0; j < WORDS_PER_FMA; j++)
               op_q[i][j] <= '0;
      end else if (word_take) begin
         for (int i = 0; i < NUM_FMAS; i++)
            for (int j = 0; j < WORDS_PER_FMA; j++)
               if (count_q == CNT_W'(i * WORDS_PER_FMA + j))
                  op_q[i][j] <= bus.word_in;
      end
   end

   // A stray word outranks the clear from a simultaneous start.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)                                  overrun_q <= 1'b0;
      else if (bus.word_valid_in && state_q != FILL) overrun_q <= 1'b1;
      else if (start_take)                            overrun_q <= 1'b0;
   end

   assign bus.busy_out      = (state_q != IDLE);
   assign bus.fma_valid_out = (state_q == PRESENT);
   assign bus.done_out      = (state_q == PRESENT) && bus.fma_ready_in;
   assign bus.overrun_out   = overrun_q;

   for (genvar i = 0; i < NUM_FMAS; i++) begin : g_pack
      assign bus.fma_a_out[i*DATA_WIDTH +: DATA_WIDTH] = op_q[i][0];
      assign bus.fma_b_out[i*DATA_WIDTH +: DATA_WIDTH] = op_q[i][1];
      assign bus.fma_c_out[i*DATA_WIDTH +: DATA_WIDTH] = op_q[i][2];
   end
endmodule

// File: tb/tb_data_buffer.sv
// tb/tb_data_buffer.sv - directed scoreboard bench for data_buffer
module tb_data_buffer;
   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   exp_t last_e;

   data_buffer_if #(.DATA_WIDTH(16), .NUM_FMAS(4)) bus ();

   data_buffer #(.DATA_WIDTH(16), .NUM_FMAS(4), .WORDS_PER_FMA(3)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t build_exp(input logic [15:0] base);
      exp_t e;
      e.a = '0; e.b = '0; e.c = '0;
      for (int k = 0; k < 12; k++) begin
         case (k % 3)
            0: e.a[(k/3)*16 +: 16] = base + 16'(k);
            1: e.b[(k/3)*16 +: 16] = base + 16'(k);
            default: e.c[(k/3)*16 +: 16] = base + 16'(k);
         endcase
      end
      return e;
   endfunction

   task automatic check_ops(input string tag, input exp_t e);
      chk({tag, "_a"}, bus.fma_a_out, e.a);
      chk({tag, "_b"}, bus.fma_b_out, e.b);
      chk({tag, "_c"}, bus.fma_c_out, e.c);
   endtask

   task automatic burst(input logic [15:0] base, input int gap, input bit rdy,
                        input bit pulse_start, input bit stray_start, input exp_t e);
      int cyc;
      sb.push_back(e);
      bus.fma_ready_in  = rdy;
      bus.start_in      = 1'b1;
      bus.word_valid_in = stray_start;
      bus.word_in       = 16'hBEEF;
      step();
      bus.start_in      = 1'b0;
      bus.word_valid_in = 1'b0;
      chk("busy_after_start", bus.busy_out, 1);
      chk("overrun_after_start", bus.overrun_out, stray_start);
      cyc = 0;
      for (int k = 0; k < 12; k++) begin
         repeat (gap) begin
            cyc++;
            bus.start_in = pulse_start && (cyc == 3 || cyc == 8);
            step();
            bus.start_in = 1'b0;
            chk("valid_in_gap", bus.fma_valid_out, 0);
         end
         cyc++;
         bus.start_in      = pulse_start && (cyc == 3 || cyc == 8);
         bus.word_valid_in = 1'b1;
         bus.word_in       = base + 16'(k);
         step();
         bus.start_in      = 1'b0;
         bus.word_valid_in = 1'b0;
         if (k < 11) begin
            chk("valid_in_fill", bus.fma_valid_out, 0);
            chk("done_in_fill", bus.done_out, 0);
         end
      end
      chk("valid_after_last", bus.fma_valid_out, 1);
   endtask

   task automatic present(input int stall, input bit stray);
      exp_t e;
      chk("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         for (int i = 0; i < stall; i++) begin
            bus.fma_ready_in  = 1'b0;
            bus.word_valid_in = stray && (i == 0);
            bus.word_in       = 16'hBEEF;
            #1;
            chk("done_stalled", bus.done_out, 0);
            chk("valid_stalled", bus.fma_valid_out, 1);
            check_ops("ops_stalled", e);
            step();
            bus.word_valid_in = 1'b0;
            if (stray) chk("overrun_present", bus.overrun_out, 1);
         end
         bus.fma_ready_in = 1'b1;
         #1;
         chk("done_pulse", bus.done_out, 1);
         check_ops("ops_present", e);
         step();
         bus.fma_ready_in = 1'b0;
         chk("valid_after_hs", bus.fma_valid_out, 0);
         chk("busy_after_hs", bus.busy_out, 0);
         chk("done_after_hs", bus.done_out, 0);
         last_e = e;
      end
   endtask

   initial begin
      exp_t basic;
      rst_n             = 1'b0;
      bus.start_in      = 1'b0;
      bus.word_valid_in = 1'b0;
      bus.word_in       = '0;
      bus.fma_ready_in  = 1'b0;
      basic = '{a: 64'h000A_0007_0004_0001, b: 64'h000B_0008_0005_0002,
                c: 64'h000C_0009_0006_0003};
      #12;
      chk("rst_busy", bus.busy_out, 0);
      chk("rst_valid", bus.fma_valid_out, 0);
      chk("rst_done", bus.done_out, 0);
      chk("rst_overrun", bus.overrun_out, 0);
      check_ops("rst_ops", '{a: 64'h0, b: 64'h0, c: 64'h0});
      rst_n = 1'b1;
      step();

      burst(16'h0001, 0, 1'b1, 1'b0, 1'b0, basic);
      present(0, 1'b0);

      bus.word_valid_in = 1'b1;
      bus.word_in       = 16'hBEEF;
      step();
      bus.word_valid_in = 1'b0;
      chk("overrun_idle", bus.overrun_out, 1);
      check_ops("ops_after_stray", last_e);

      burst(16'h0001, 1, 1'b0, 1'b0, 1'b0, basic);
      present(5, 1'b1);

      bus.start_in = 1'b1;
      step();
      bus.start_in = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.word_valid_in = 1'b1;
         bus.word_in       = 16'h7700 + 16'(k);
         step();
      end
      bus.word_valid_in = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("amid_busy", bus.busy_out, 0);
      chk("amid_valid", bus.fma_valid_out, 0);
      chk("amid_done", bus.done_out, 0);
      chk("amid_overrun", bus.overrun_out, 0);
      check_ops("amid_ops", '{a: 64'h0, b: 64'h0, c: 64'h0});
      rst_n = 1'b1;
      step();

      burst(16'h0100, 0, 1'b1, 1'b0, 1'b0, build_exp(16'h0100));
      present(0, 1'b0);

      burst(16'h2000, 0, 1'b0, 1'b1, 1'b0, build_exp(16'h2000));
      present(2, 1'b0);

      burst(16'h3000, 2, 1'b1, 1'b0, 1'b1, build_exp(16'h3000));
      present(0, 1'b0);
      chk("sb_drained", 64'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
